writeback_arbiter: RTL

Merges register writes from the single-cycle execute/memory pipeline and from long-latency units (loads, divider) into the single write port of the register file. Holds returning long-latency results in a small queue, tracks pending destinations in a scoreboard so decode can stall on RAW/WAW hazards, and prevents queue starvation by briefly stalling the pipeline. Sits between the mem/execute stages and the register file; its `rf_*` outputs drive the register file write port directly.

---
 rtl/writeback_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : writeback_arbiter
// Merges pipeline and long-latency results onto the single register file
// write port; tracks pending destinations for decode hazard stalls.
// Rev 1.0 : initial release
// ============================================================================
module writeback_arbiter #(
   parameter int XLEN       = 32,
   parameter int LQ_DEPTH   = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            pipe_valid_i,
   input  logic [4:0]      pipe_rd_i,
   input  logic [XLEN-1:0] pipe_data_i,
   output logic            pipe_stall_o,
   input  logic            issue_valid_i,
   input  logic [4:0]      issue_rd_i,
   output logic            issue_ready_o,
   input  logic            lat_valid_i,
   input  logic [4:0]      lat_rd_i,
   input  logic [XLEN-1:0] lat_data_i,
   output logic            lat_ready_o,
   input  logic [4:0]      rs1_i,
   input  logic [4:0]      rs2_i,
   output logic            rs1_busy_o,
   output logic            rs2_busy_o,
   output logic [4:0]      rf_rd_o,
   output logic [XLEN-1:0] rf_din_o,
   output logic            rf_we_o
);

   localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [PW:0]   DEPTH_C  = (PW+1)'(LQ_DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

   logic [4:0]      q_rd   [LQ_DEPTH];
   logic [XLEN-1:0] q_data [LQ_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count, outstanding;
   logic [SW-1:0]   starve_cnt;
   logic [31:0]     pending, pending_next;

   logic q_nonempty, starved, pop, push, pipe_win, issue_acc;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_data;

   assign q_nonempty = (count != '0);
   assign starved    = q_nonempty && (starve_cnt == STARVE_C);
   assign pipe_win   = pipe_valid_i && !starved;
   assign pop        = q_nonempty && !pipe_win;
   assign lat_ready_o = (count != DEPTH_C);
   // A push while full is a protocol violation and is dropped here.
   assign push       = lat_valid_i && lat_ready_o;
   assign head_rd    = q_rd[rd_ptr];
   assign head_data  = q_data[rd_ptr];

   assign pipe_stall_o  = starved;
   assign issue_ready_o = (outstanding < DEPTH_C) && !pending[issue_rd_i];
   assign issue_acc     = issue_valid_i && issue_ready_o;
   assign rs1_busy_o    = pending[rs1_i];
   assign rs2_busy_o    = pending[rs2_i];

   // Set after clear so a same-cycle issue to the popped rd stays pending.
   always_comb begin
      pending_next = pending;
      if (pop)
         pending_next[head_rd] = 1'b0;
      if (issue_acc && (issue_rd_i != 5'd0))
         pending_next[issue_rd_i] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         q_rd[wr_ptr]   <= lat_rd_i;
         q_data[wr_ptr] <= lat_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         starve_cnt  <= '0;
         pending     <= '0;
      end else begin
         pending <= pending_next;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         case ({issue_acc, pop})
            2'b10:   outstanding <= outstanding + (PW+1)'(1);
            2'b01:   outstanding <= outstanding - (PW+1)'(1);
            default: outstanding <= outstanding;
         endcase
         if (pop || !q_nonempty)
            starve_cnt <= '0;
         else if (pipe_win && (starve_cnt != STARVE_C))
            starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // Winners with rd == 0 are consumed but never reach the register file.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rf_we_o  <= 1'b0;
         rf_rd_o  <= '0;
         rf_din_o <= '0;
      end else begin
         rf_we_o <= 1'b0;
         if (pop) begin
            rf_we_o  <= (head_rd != 5'd0);
            rf_rd_o  <= head_rd;
            rf_din_o <= head_data;
         end else if (pipe_win) begin
            rf_we_o  <= (pipe_rd_i != 5'd0);
            rf_rd_o  <= pipe_rd_i;
            rf_din_o <= pipe_data_i;
         end
      end
   end

endmodule
`default_nettype wire
